// File: rtl/pkg_req_port.sv
// Requester-side input port for the round-robin package arbiter: buffers flits,
// requests the decoded destination, streams the granted packet and pulses release.
module pkg_req_port #(
  parameter int unsigned NUM_REQUESTERS = 5,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DEPTH          = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_flit,
  output logic                      in_ready,
  output logic [NUM_REQUESTERS-1:0] req,
  input  logic                      gnt,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_flit,
  input  logic                      out_ready,
  output logic                      pkt_release,
  output logic [7:0]                drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {StIdle, StReq, StXfer, StRel, StDrop} state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q, rd_ptr_q;
  logic                  empty, full, push, pop, drop_evt;
  logic [1:0]            front_type;
  logic [2:0]            front_dest;
  logic                  dest_ok;
  logic [2:0]            dest_q, dest_d;
  logic [7:0]            drop_cnt_q;
  state_e                state_q, state_d;

  // Wrap bit differs with equal index bits when the FIFO is full.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign drop_cnt = drop_cnt_q;

  assign out_flit   = mem_q[rd_ptr_q[AW-1:0]];
  assign front_type = out_flit[1:0];
  assign front_dest = out_flit[4:2];
  assign dest_ok    = 32'(front_dest) < NUM_REQUESTERS;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_flit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
      dest_q     <= '0;
      state_q    <= StIdle;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop_evt && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      dest_q  <= dest_d;
      state_q <= state_d;
    end
  end

  // type[0] marks a packet start (head/single), type[1] a packet end (tail/single).
  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    pop      = 1'b0;
    drop_evt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          if (front_type[0]) begin
            drop_evt = !dest_ok;
            if (dest_ok) begin
              dest_d  = front_dest;
              state_d = StReq;
            end else begin
              state_d = StDrop;
            end
          end else begin
            pop      = 1'b1;
            drop_evt = 1'b1;
          end
        end
      end
      StReq: begin
        if (gnt) state_d = StXfer;
      end
      StXfer: begin
        if (!empty && out_ready) begin
          pop = 1'b1;
          if (front_type[1]) state_d = StRel;
        end
      end
      StRel: state_d = StIdle;
      StDrop: begin
        if (!empty) begin
          pop = 1'b1;
          if (front_type[1]) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req         = '0;
    out_valid   = 1'b0;
    pkt_release = 1'b0;
    case (state_q)
      StReq:   req = NUM_REQUESTERS'(1) << dest_q;
      StXfer: begin
        req       = NUM_REQUESTERS'(1) << dest_q;
        out_valid = !empty;
      end
      StRel:   pkt_release = 1'b1;
      default: ;
    endcase
  end

endmodule
